// File: rtl/csr_timer_bank_pkg.sv
// Shared constants and types for the CSR-mapped timer bank.
// Pure declarations: no logic, no latency, no flow control.
package csr_timer_bank_pkg;

    localparam logic [11:0] TimerBankBaseAddr       = 12'h400;
    localparam int          TimerBankChannels       = 4;
    localparam int          TimerBankCounterWidth   = 16;
    localparam int          TimerBankPrescalerWidth = 4;

    typedef enum logic [1:0] {
        CSR_WRITE = 2'd0,
        CSR_SET   = 2'd1,
        CSR_CLEAR = 2'd2,
        CSR_READ  = 2'd3
    } CsrOpT;

    // Low fields keep the legacy single-timer packing, prescaler at bit 0.
    typedef struct packed {
        logic                               one_shot;
        logic                               enable;
        logic [TimerBankCounterWidth-1:0]   counter_top;
        logic [TimerBankPrescalerWidth-1:0] prescaler;
    } TimerCtrlT;

endpackage

// File: rtl/csr_timer_bank_channel.sv
// One timer channel: control register, prescaler, counter, registered irq pulse.
// Update applies on the next edge; no backpressure. Count port exists with CSR_TIMER_BANK_COUNT_READ_EN.
module timer_channel #(
    parameter int CounterWidth   = 16,
    parameter int PrescalerWidth = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   upd,
    input  logic [PrescalerWidth+CounterWidth+1:0] upd_val,
    output logic [PrescalerWidth+CounterWidth+1:0] ctrl,
    output logic                                   irq
`ifdef CSR_TIMER_BANK_COUNT_READ_EN
    ,
    output logic [CounterWidth-1:0]                count
`endif
);

    localparam int EnBit = PrescalerWidth + CounterWidth;
    localparam logic [CounterWidth-1:0]   CntOne = 1;
    localparam logic [PrescalerWidth-1:0] PreOne = 1;

    logic [PrescalerWidth-1:0] pcnt;
    logic [CounterWidth-1:0]   cnt;
    logic [PrescalerWidth-1:0] presc;
    logic [CounterWidth-1:0]   top;
    logic                      en;
    logic                      one_shot;

    assign presc    = ctrl[PrescalerWidth-1:0];
    assign top      = ctrl[EnBit-1:PrescalerWidth];
    assign en       = ctrl[EnBit];
    assign one_shot = ctrl[EnBit+1];

    // A CSR update restarts the channel and takes priority over a terminal tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= '0;
            pcnt <= '0;
            cnt  <= '0;
            irq  <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (upd) begin
                ctrl <= upd_val;
                pcnt <= '0;
                cnt  <= '0;
            end else if (en) begin
                if (pcnt == presc) begin
                    pcnt <= '0;
                    if (cnt == top) begin
                        cnt <= '0;
                        irq <= 1'b1;
                        if (one_shot) begin
                            ctrl[EnBit] <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CntOne;
                    end
                end else begin
                    pcnt <= pcnt + PreOne;
                end
            end
        end
    end

`ifdef CSR_TIMER_BANK_COUNT_READ_EN
    assign count = cnt;
`endif

endmodule

// File: rtl/csr_timer_bank.sv
// Bank of CSR timers: address decode, write/set/clear merge, combinational read mux.
// Writes commit on the access edge, irq is registered; no backpressure. Option: CSR_TIMER_BANK_COUNT_READ_EN.
module csr_timer_bank
    import csr_timer_bank_pkg::*;
#(
    parameter int          NumChannels    = TimerBankChannels,
    parameter int          CounterWidth   = TimerBankCounterWidth,
    parameter int          PrescalerWidth = TimerBankPrescalerWidth,
    parameter logic [11:0] BaseAddr       = TimerBankBaseAddr
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   csr_enable,
    input  logic [11:0]            csr_addr,
    input  logic [1:0]             csr_op,
    input  logic [31:0]            csr_wdata,
    output logic [31:0]            csr_rdata,
    output logic [NumChannels-1:0] irq
);

    localparam int RegWidth = PrescalerWidth + CounterWidth + 2;

    logic [RegWidth-1:0]    ctrl   [NumChannels];
    logic [RegWidth-1:0]    merged [NumChannels];
    logic [NumChannels-1:0] sel;
    logic [NumChannels-1:0] upd;
    logic [11:0]            offset;
    logic                   modify;
    CsrOpT                  op;

    assign op     = CsrOpT'(csr_op);
    assign offset = csr_addr - BaseAddr;
    // Set/clear with a zero operand is a no-op and must not restart the channel.
    assign modify = (op == CSR_WRITE) ||
                    (((op == CSR_SET) || (op == CSR_CLEAR)) && (csr_wdata != '0));

    always_comb begin
        sel = '0;
        upd = '0;
        for (int i = 0; i < NumChannels; i++) begin
            sel[i] = csr_enable && (offset == 12'(i));
            upd[i] = sel[i] && modify;
            case (op)
                CSR_SET:   merged[i] = ctrl[i] | csr_wdata[RegWidth-1:0];
                CSR_CLEAR: merged[i] = ctrl[i] & ~csr_wdata[RegWidth-1:0];
                default:   merged[i] = csr_wdata[RegWidth-1:0];
            endcase
        end
    end

`ifdef CSR_TIMER_BANK_COUNT_READ_EN
    logic [CounterWidth-1:0] count [NumChannels];
    logic [NumChannels-1:0]  csel;
    logic [11:0]             cnt_offset;

    assign cnt_offset = csr_addr - (BaseAddr + 12'(NumChannels));

    always_comb begin
        csel = '0;
        for (int i = 0; i < NumChannels; i++) begin
            csel[i] = csr_enable && (cnt_offset == 12'(i));
        end
    end
`endif

    for (genvar g = 0; g < NumChannels; g++) begin : g_ch
        timer_channel #(
            .CounterWidth   (CounterWidth),
            .PrescalerWidth (PrescalerWidth)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .upd     (upd[g]),
            .upd_val (merged[g]),
            .ctrl    (ctrl[g]),
            .irq     (irq[g])
`ifdef CSR_TIMER_BANK_COUNT_READ_EN
            ,
            .count   (count[g])
`endif
        );
    end

    // Read returns the pre-write register value; unaddressed reads are 0.
    always_comb begin
        csr_rdata = '0;
        for (int i = 0; i < NumChannels; i++) begin
            if (sel[i]) begin
                csr_rdata = 32'(ctrl[i]);
            end
`ifdef CSR_TIMER_BANK_COUNT_READ_EN
            if (csel[i]) begin
                csr_rdata = 32'(count[i]);
            end
`endif
        end
    end

endmodule
